// File: rtl/bin2bcd_conv.sv
// ============================================================================
// Module      : bin2bcd_conv
// Description : Sequential shift-and-add-3 binary-to-BCD converter, one bit
//               per clock, feeding the four-digit seven-segment scanner.
//               BIN2BCD_SAT_EN: overflow loads 16'h9999 instead of 16'hEEEE.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bin2bcd_conv #(
  parameter int BIN_W = 14
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [BIN_W-1:0] DIN,
  output logic [15:0]      DOUT,
  output logic             BUSY,
  output logic             DONE,
  output logic             OVF
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  localparam logic [3:0] c_LAST = 4'(BIN_W - 1);
`ifdef BIN2BCD_SAT_EN
  localparam logic [15:0] c_OVF_CODE = 16'h9999;
`else
  localparam logic [15:0] c_OVF_CODE = 16'hEEEE;
`endif

  state_t           r_state;
  logic [BIN_W-1:0] r_bin;
  logic [15:0]      r_bcd;
  logic [3:0]       r_cnt;
  logic             r_rng;

  logic [15:0]      w_adj;
  logic [15:0]      w_bcd_nxt;
  logic [BIN_W-1:0] w_bin_nxt;
  logic             w_rng;

  // Nibbles never exceed 12 after the adjust, so no carry crosses nibbles.
  for (genvar gi = 0; gi < 4; gi++) begin : g_nib
    assign w_adj[4*gi +: 4] = (r_bcd[4*gi +: 4] >= 4'd5) ? r_bcd[4*gi +: 4] + 4'd3
                                                         : r_bcd[4*gi +: 4];
  end

  assign w_bcd_nxt = 16'({w_adj, r_bin[BIN_W-1]});
  assign w_bin_nxt = {r_bin[BIN_W-2:0], 1'b0};
  assign w_rng     = (32'(DIN) > 32'd9999);

  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_state <= ST_IDLE;
      r_bin   <= '0;
      r_bcd   <= '0;
      r_cnt   <= '0;
      r_rng   <= 1'b0;
      DOUT    <= '0;
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
      OVF     <= 1'b0;
    end else begin
      DONE <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (START) begin
            r_bin   <= DIN;
            r_bcd   <= '0;
            r_cnt   <= '0;
            r_rng   <= w_rng;
            BUSY    <= 1'b1;
            r_state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          r_bcd <= w_bcd_nxt;
          r_bin <= w_bin_nxt;
          r_cnt <= r_cnt + 4'd1;
          if (r_cnt == c_LAST) begin
            DOUT    <= r_rng ? c_OVF_CODE : w_bcd_nxt;
            OVF     <= r_rng;
            DONE    <= 1'b1;
            BUSY    <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_bin2bcd_conv.sv
// ============================================================================
// Module      : tb_bin2bcd_conv
// Description : Directed self-checking bench for bin2bcd_conv (BIN_W = 14).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bin2bcd_conv;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [13:0] din = '0;
  logic [15:0] dout;
  logic        busy, done, ovf;

  int total = 0;
  int bad   = 0;

`ifdef BIN2BCD_SAT_EN
  localparam logic [15:0] c_OVF_EXP = 16'h9999;
`else
  localparam logic [15:0] c_OVF_EXP = 16'hEEEE;
`endif

  bin2bcd_conv #(.BIN_W(14)) u_dut (
    .CLK   (clk),
    .RST   (rst),
    .START (start),
    .DIN   (din),
    .DOUT  (dout),
    .BUSY  (busy),
    .DONE  (done),
    .OVF   (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Called #1 after an edge with the DUT idle; returns #1 after the accept edge.
  task automatic start_conv(input logic [13:0] v);
    start = 1'b1;
    din   = v;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    for (int i = 1; i <= 30; i++) begin
      @(posedge clk); #1;
      if (done) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic run(input string tag, input logic [13:0] v,
                     input logic [15:0] exp, input logic exp_ovf);
    int errs;
    errs = 0;
    start_conv(v);
    chk({tag, "_busy_e0"}, busy, 1);
    for (int i = 1; i < 14; i++) begin
      din = 14'($urandom);
      @(posedge clk); #1;
      if (busy !== 1'b1 || done !== 1'b0) errs++;
    end
    chk({tag, "_busy_run"}, errs, 0);
    @(posedge clk); #1;
    chk({tag, "_done"}, done, 1);
    chk({tag, "_busy_end"}, busy, 0);
    chk({tag, "_dout"}, dout, exp);
    chk({tag, "_ovf"}, ovf, exp_ovf);
    @(posedge clk); #1;
    chk({tag, "_done_clr"}, done, 0);
  endtask

  initial begin
    int n;
    int dones;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_dout", dout, 16'h0000);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ovf", ovf, 0);
    rst = 1'b1;
    @(posedge clk); #1;

    run("d1234", 14'd1234, 16'h1234, 1'b0);
    run("d0", 14'd0, 16'h0000, 1'b0);
    run("d9999", 14'd9999, 16'h9999, 1'b0);
    run("d5", 14'd5, 16'h0005, 1'b0);
    run("d10000", 14'd10000, c_OVF_EXP, 1'b1);
    run("d16383", 14'd16383, c_OVF_EXP, 1'b1);

    // START during a conversion is ignored and not queued
    dones = 0;
    start_conv(14'd42);
    for (int i = 1; i < 14; i++) begin
      start = (i == 5);
      if (i == 5) din = 14'd777;
      @(posedge clk); #1;
      if (done) dones++;
    end
    start = 1'b0;
    @(posedge clk); #1;
    chk("ign_done", done, 1);
    chk("ign_early_done", dones, 0);
    chk("ign_dout", dout, 16'h0042);
    chk("ign_ovf", ovf, 0);

    // START in the DONE cycle is accepted
    start_conv(14'd777);
    wait_done(n);
    chk("b2b_lat", n, 14);
    chk("b2b_dout", dout, 16'h0777);
    @(posedge clk); #1;
    chk("b2b_single", done, 0);

    // Reset mid-conversion aborts without a DONE pulse
    run("pre_rst", 14'd1234, 16'h1234, 1'b0);
    start_conv(14'd8888);
    repeat (6) begin
      @(posedge clk); #1;
    end
    rst = 1'b0;
    @(posedge clk); #1;
    chk("abort_dout", dout, 16'h0000);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    rst = 1'b1;
    dones = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done || busy) dones++;
    end
    chk("abort_quiet", dones, 0);
    start_conv(14'd8888);
    wait_done(n);
    chk("post_rst_lat", n, 14);
    chk("post_rst_dout", dout, 16'h8888);
    chk("post_rst_ovf", ovf, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
